// File: rtl/serial_pkg.sv
// Shared constants for the serial sequence-detector path: bit-order selectors and
// default serializer settings.
package serial_pkg;

    localparam bit          MSB_FIRST        = 1'b1;
    localparam bit          LSB_FIRST        = 1'b0;
    localparam bit          DEFAULT_IDLE_BIT = 1'b0;
    localparam int unsigned DEFAULT_WIDTH    = 8;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry word buffer with write enable, clear and a full flag; ready is forced
// low while reset is asserted so nothing is accepted on a reset edge.
module word_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             ready
);

    assign ready = !full && !reset;

    // Write and clear are mutually exclusive in use: write needs !full, clear needs full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (wr_en) begin
            data_out <= data_in;
            full     <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: buffers one word and shifts words out one bit per
// enabled cycle, loading the buffered word on the en-edge the shifter empties.
module bit_serializer #(
    parameter int unsigned WIDTH     = serial_pkg::DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = serial_pkg::MSB_FIRST,
    parameter bit          IDLE_BIT  = serial_pkg::DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_first,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;
    logic             load;

    assign accept = data_valid && data_ready;
    assign load   = en && (cnt == '0) && hold_full;

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .clr     (load),
        .data_in (data_in),
        .data_out(hold),
        .full    (hold_full),
        .ready   (data_ready)
    );

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            word_done <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
        end else if (en) begin
            if (cnt != '0) begin
                out       <= head(sh);
                sh        <= advance(sh);
                cnt       <= cnt - CW'(1);
                out_valid <= 1'b1;
                out_first <= 1'b0;
                word_done <= (cnt == CW'(1));
            end else if (hold_full) begin
                out       <= head(hold);
                sh        <= advance(hold);
                cnt       <= CW'(WIDTH - 1);
                out_valid <= 1'b1;
                out_first <= 1'b1;
                word_done <= 1'b0;
            end else begin
                out       <= IDLE_BIT;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                word_done <= 1'b0;
            end
        end else begin
            // out and out_valid hold the current bit between strobes
            out_first <= 1'b0;
            word_done <= 1'b0;
        end
    end

    assign busy = (cnt != '0) || hold_full || (out_valid && !word_done);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share stimulus and
// are checked every cycle against a bit-index model, plus literal stream checks.
module tb_bit_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         dv;
    logic [W-1:0] din;

    logic [1:0] o_ready, o_out, o_valid, o_first, o_done, o_busy;

    bit_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(1'b1),
        .IDLE_BIT (1'b0)
    ) u_msb (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .data_in   (din),
        .data_valid(dv),
        .data_ready(o_ready[0]),
        .out       (o_out[0]),
        .out_valid (o_valid[0]),
        .out_first (o_first[0]),
        .word_done (o_done[0]),
        .busy      (o_busy[0])
    );

    bit_serializer #(
        .WIDTH    (W),
        .MSB_FIRST(1'b0),
        .IDLE_BIT (1'b1)
    ) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .data_in   (din),
        .data_valid(dv),
        .data_ready(o_ready[1]),
        .out       (o_out[1]),
        .out_valid (o_valid[1]),
        .out_first (o_first[1]),
        .word_done (o_done[1]),
        .busy      (o_busy[1])
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the word in flight is sent as bit index 0..W-1 in send order.
    logic [W-1:0] m_word [2];
    logic [W-1:0] m_hold [2];
    int           m_rem  [2];
    int           m_next [2];
    bit           m_full [2];
    bit           m_out  [2];
    bit           m_valid[2];
    bit           m_first[2];
    bit           m_done [2];
    bit           m_acc  [2];
    bit           m_msb  [2];
    bit           m_idle [2];

    logic [31:0] col_m, col_l;
    int          n_m, n_l, cur_run, max_run, n_first;
    bit          col_on = 1'b0;
    int          phase  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit nth_bit(input logic [W-1:0] w, input int k, input bit msb);
        return msb ? w[W-1-k] : w[k];
    endfunction

    task automatic step(input int i);
        bit acc;
        if (reset) begin
            m_full[i]  = 1'b0;
            m_rem[i]   = 0;
            m_out[i]   = m_idle[i];
            m_valid[i] = 1'b0;
            m_first[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_acc[i]   = 1'b0;
            return;
        end
        acc = dv && !m_full[i];
        if (en) begin
            if (m_rem[i] > 0) begin
                m_out[i]   = nth_bit(m_word[i], m_next[i], m_msb[i]);
                m_next[i]  = m_next[i] + 1;
                m_rem[i]   = m_rem[i] - 1;
                m_valid[i] = 1'b1;
                m_first[i] = 1'b0;
                m_done[i]  = (m_rem[i] == 0);
            end else if (m_full[i]) begin
                m_word[i]  = m_hold[i];
                m_out[i]   = nth_bit(m_word[i], 0, m_msb[i]);
                m_next[i]  = 1;
                m_rem[i]   = W - 1;
                m_full[i]  = 1'b0;
                m_valid[i] = 1'b1;
                m_first[i] = 1'b1;
                m_done[i]  = 1'b0;
            end else begin
                m_out[i]   = m_idle[i];
                m_valid[i] = 1'b0;
                m_first[i] = 1'b0;
                m_done[i]  = 1'b0;
            end
        end else begin
            m_first[i] = 1'b0;
            m_done[i]  = 1'b0;
        end
        if (acc) begin
            m_hold[i] = din;
            m_full[i] = 1'b1;
        end
        m_acc[i] = acc;
    endtask

    task automatic check(input int i);
        chk($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(!m_full[i] && !reset));
        chk($sformatf("out%0d", i), 32'(o_out[i]), 32'(m_out[i]));
        chk($sformatf("out_valid%0d", i), 32'(o_valid[i]), 32'(m_valid[i]));
        chk($sformatf("out_first%0d", i), 32'(o_first[i]), 32'(m_first[i]));
        chk($sformatf("word_done%0d", i), 32'(o_done[i]), 32'(m_done[i]));
        chk($sformatf("busy%0d", i), 32'(o_busy[i]),
            32'((m_rem[i] > 0) || m_full[i] || (m_valid[i] && !m_done[i])));
    endtask

    // One clock: model steps on the inputs the posedge saw, then outputs are compared.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step(i);
            check(i);
        end
        if (col_on) begin
            if (o_first[0]) n_first++;
            if (en) begin
                if (o_valid[0]) begin
                    col_m = {col_m[30:0], o_out[0]};
                    n_m++;
                    cur_run++;
                    if (cur_run > max_run) max_run = cur_run;
                end else begin
                    cur_run = 0;
                end
                if (o_valid[1]) begin
                    col_l = {col_l[30:0], o_out[1]};
                    n_l++;
                end
            end
        end
    endtask

    task automatic tick_slow();
        en    = (phase == 0);
        phase = (phase + 1) % 3;
        tick();
    endtask

    task automatic start_col();
        col_on  = 1'b1;
        col_m   = '0;
        col_l   = '0;
        n_m     = 0;
        n_l     = 0;
        cur_run = 0;
        max_run = 0;
        n_first = 0;
    endtask

    task automatic wait_accept(input string name, input bit slow);
        for (int k = 0; k < 60; k++) begin
            if (slow) tick_slow();
            else tick();
            if (m_acc[0]) break;
        end
        chk(name, 32'(m_acc[0]), 32'd1);
    endtask

    initial begin
        int det;
        m_msb[0]  = 1'b1;
        m_msb[1]  = 1'b0;
        m_idle[0] = 1'b0;
        m_idle[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_rem[i] = 0; m_next[i] = 0; m_out[i] = m_idle[i];
            m_valid[i] = 0; m_first[i] = 0; m_done[i] = 0; m_acc[i] = 0;
            m_word[i] = '0; m_hold[i] = '0;
        end
        reset = 1'b1;
        en    = 1'b0;
        dv    = 1'b1;
        din   = 8'h77;
        repeat (3) tick();
        chk("reset_ready", 32'(o_ready[0]), 32'd0);
        chk("reset_valid", 32'(o_valid[0]), 32'd0);
        reset = 1'b0;
        dv    = 1'b0;
        en    = 1'b1;
        tick();

        // Basic MSB-first send of 8'hB0
        start_col();
        dv  = 1'b1;
        din = 8'hB0;
        wait_accept("b0_accept", 1'b0);
        dv = 1'b0;
        tick();
        chk("b0_first_latency", 32'(o_first[0]), 32'd1);
        repeat (8) tick();
        chk("b0_valid_after", 32'(o_valid[0]), 32'd0);
        chk("b0_nbits", 32'(n_m), 32'd8);
        chk("b0_msb_stream", {24'd0, col_m[7:0]}, 32'h0000_00B0);
        chk("b0_lsb_stream", {24'd0, col_l[7:0]}, 32'h0000_000D);

        // Back-to-back A5, 3C with data_valid held high
        start_col();
        dv  = 1'b1;
        din = 8'hA5;
        wait_accept("b2b_accept0", 1'b0);
        din = 8'h3C;
        wait_accept("b2b_accept1", 1'b0);
        dv = 1'b0;
        repeat (20) tick();
        chk("b2b_nbits", 32'(n_m), 32'd16);
        chk("b2b_stream", {16'd0, col_m[15:0]}, 32'h0000_A53C);
        chk("b2b_contiguous", 32'(max_run), 32'd16);

        // Slow strobe: en every third cycle
        start_col();
        phase = 0;
        dv    = 1'b1;
        din   = 8'hB0;
        wait_accept("slow_accept", 1'b1);
        dv = 1'b0;
        repeat (40) tick_slow();
        chk("slow_nbits", 32'(n_m), 32'd8);
        chk("slow_stream", {24'd0, col_m[7:0]}, 32'h0000_00B0);
        chk("slow_first_pulses", 32'(n_first), 32'd1);

        // Backpressure: data_valid held, data_in changes every cycle
        col_on = 1'b0;
        en     = 1'b1;
        dv     = 1'b1;
        for (int k = 0; k < 40; k++) begin
            din = W'($urandom);
            tick();
        end
        dv = 1'b0;
        repeat (20) tick();

        // Reset mid-word with a second word buffered
        start_col();
        dv  = 1'b1;
        din = 8'hFF;
        wait_accept("rst_accept", 1'b0);
        din = 8'h5A;
        for (int k = 0; k < 20 && n_m < 3; k++) tick();
        chk("rst_bits_before", 32'(n_m), 32'd3);
        reset = 1'b1;
        tick();
        chk("rst_out", 32'(o_out[0]), 32'd0);
        chk("rst_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_busy", 32'(o_busy[0]), 32'd0);
        chk("rst_ready", 32'(o_ready[0]), 32'd0);
        reset = 1'b0;
        dv    = 1'b0;
        start_col();
        repeat (12) tick();
        chk("rst_no_residual", 32'(n_m), 32'd0);
        chk("rst_ready_after", 32'(o_ready[0]), 32'd1);

        // LSB-first send of 8'h0D, with a 1011 detector over the valid bits
        start_col();
        dv  = 1'b1;
        din = 8'h0D;
        wait_accept("lsb_accept", 1'b0);
        dv = 1'b0;
        repeat (10) tick();
        chk("lsb_nbits", 32'(n_l), 32'd8);
        chk("lsb_stream", {24'd0, col_l[7:0]}, 32'h0000_00B0);
        det = 0;
        for (int k = 7; k >= 3; k--) if (col_l[k-:4] == 4'b1011) det++;
        chk("lsb_detect_1011", 32'(det), 32'd1);

        // Randomized soak
        col_on = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 9) < 7);
            dv    = $urandom_range(0, 1) == 1;
            din   = W'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
